ram_sweep_sp: RTL and testbench

Parametrised single-port synchronous RAM; successor to the 1-bit/64-entry scratch RAM in the simplest2 microprocessor. Adds configurable width and depth, a registered read with valid flag, and a sequential clear engine that zeroes the array one word per cycle, replacing the old instantaneous whole-array clear. Sits between the control unit and the datapath as general data/scratch storage.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_clear_sweeper.sv | 48 ++++
 rtl/ram_sweep_sp.sv | 119 +++++++++++
 tb/tb_ram_sweep_sp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types, defaults and the parity helper for the sweep-cleared scratch RAM.
// Latency: n/a (declarations only). Backpressure: n/a.
package ram_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_ADDR_W = 6;
  // Widest data word the parity helper can cover.
  localparam int PARITY_MAX_W   = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_clear_sweeper.sv
// Clear engine: zeroes one word per cycle from address 0 to DEPTH-1 after reset or clear.
// Latency: clear takes effect on the edge it is sampled. Backpressure: none, busy is advisory to the owner.
module ram_clear_sweeper
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      // The clear edge itself zeroes address 0; the sweep then starts again from 0.
      state_d = SWEEP;
      cnt_d   = '0;
    end else if (state_q == SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = IDLE;
      end
    end
  end

  assign busy       = !rst_n || (state_q == SWEEP);
  assign sweep_we   = rst_n && (clear || (state_q == SWEEP));
  assign sweep_addr = clear ? '0 : cnt_q;

endmodule

// File: rtl/ram_sweep_sp.sv
// Single-port scratch RAM with registered read, rd_valid pulse and a sequential clear sweep.
// Optional RAM_PARITY_EN adds a stored even-parity bit per word and a read parity_err flag.
module ram_sweep_sp
  import ram_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  datain,
  input  logic              store,
  input  logic              rd_en,
  input  logic              clear,
  output logic [WIDTH-1:0]  dataout,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_drop,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              idle, wr_ok, rd_ok;
  logic [MEM_W-1:0]  wr_word, rd_word;

  logic [WIDTH-1:0]  dataout_q, dataout_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_drop_q, wr_drop_d;

  ram_clear_sweeper #(
    .ADDR_W(ADDR_W)
  ) u_sweeper (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .busy      (busy),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );

  // A clear on this edge blocks user traffic just like an ongoing sweep.
  assign idle  = !busy && !clear;
  assign wr_ok = store && idle;
  assign rd_ok = rd_en && idle;

`ifdef RAM_PARITY_EN
  assign wr_word = {even_parity(PARITY_MAX_W'(datain)), datain};
`else
  assign wr_word = datain;
`endif
  assign rd_word = mem[address];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweep_we) begin
        mem[sweep_addr] <= '0;
      end else if (wr_ok) begin
        mem[address] <= wr_word;
      end
    end
  end

  always_comb begin
    dataout_d  = dataout_q;
    rd_valid_d = rd_en;
    wr_drop_d  = store && !idle;
    if (rd_en) begin
      dataout_d = rd_ok ? rd_word[WIDTH-1:0] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataout_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      dataout_q  <= dataout_d;
      rd_valid_q <= rd_valid_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign dataout  = dataout_q;
  assign rd_valid = rd_valid_q;
  assign wr_drop  = wr_drop_q;

`ifdef RAM_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = rd_ok &&
                   (even_parity(PARITY_MAX_W'(rd_word[WIDTH-1:0])) != rd_word[WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sweep_sp.sv
// Directed plus randomized bench for ram_sweep_sp against an array-and-countdown reference model.
module tb_ram_sweep_sp;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  datain;
  logic              store, rd_en, clear;
  logic [WIDTH-1:0]  dataout;
  logic              rd_valid, busy, wr_drop, parity_err;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array, a stored-parity array, and a sweep countdown.
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_par [DEPTH];
  int               m_left;
  int               m_pos;
  logic [WIDTH-1:0] e_dout;
  logic             e_vld, e_drop, e_perr;

  ram_sweep_sp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .datain    (datain),
    .store     (store),
    .rd_en     (rd_en),
    .clear     (clear),
    .dataout   (dataout),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .wr_drop   (wr_drop),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic blocked;
    if (!rst_n) begin
      m_left = DEPTH;
      m_pos  = 0;
      e_dout = '0;
      e_vld  = 1'b0;
      e_drop = 1'b0;
      e_perr = 1'b0;
      return;
    end
    blocked = (m_left > 0) || clear;
    e_vld   = rd_en;
    e_perr  = 1'b0;
    if (rd_en) begin
      if (blocked) begin
        e_dout = '0;
      end else begin
        e_dout = m_mem[address];
        e_perr = (^m_mem[address]) != m_par[address];
      end
    end
    e_drop = store && blocked;
    if (store && !blocked) begin
      m_mem[address] = datain;
      m_par[address] = ^datain;
    end
    if (clear) begin
      m_mem[0] = '0;
      m_par[0] = 1'b0;
      m_left   = DEPTH;
      m_pos    = 0;
    end else if (m_left > 0) begin
      m_mem[m_pos] = '0;
      m_par[m_pos] = 1'b0;
      m_pos++;
      m_left--;
    end
  endtask

  task automatic step(input logic r, input logic clr, input logic st, input logic rd,
                      input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    rst_n   = r;
    clear   = clr;
    store   = st;
    rd_en   = rd;
    address = a;
    datain  = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("dataout", 32'(dataout), 32'(e_dout));
    chk("rd_valid", 32'(rd_valid), 32'(e_vld));
    chk("busy", 32'(busy), 32'(!rst_n || (m_left > 0)));
    chk("wr_drop", 32'(wr_drop), 32'(e_drop));
    chk("parity_err", 32'(parity_err), 32'(e_perr));
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      idle_step();
      n++;
    end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_par[i] = 1'b0;
    end
    m_left = DEPTH;
    m_pos  = 0;
    e_dout = '0;
    e_vld  = 1'b0;
    e_drop = 1'b0;
    e_perr = 1'b0;

    // Reset with traffic applied: everything must sit at reset values.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 6'd4, 8'h3C);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_dout", 32'(dataout), 32'd0);

    // Sweep after release: busy holds through 63 edges and drops on the 64th.
    for (int i = 0; i < DEPTH - 1; i++) idle_step();
    chk("sweep_busy_hold", 32'(busy), 32'd1);
    idle_step();
    chk("sweep_done", 32'(busy), 32'd0);

    for (int a = 0; a < DEPTH; a++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, ADDR_W'(a), '0);
      chk("swept_zero", 32'(dataout), 32'd0);
    end

    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd3, 8'hA5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd63, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd3, '0);
    chk("rd3", 32'(dataout), 32'hA5);
    chk("rd3_vld", 32'(rd_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd63, '0);
    chk("rd63", 32'(dataout), 32'h5A);
    idle_step();
    chk("vld_drop", 32'(rd_valid), 32'd0);
    chk("dout_hold", 32'(dataout), 32'h5A);

    // Read-first on simultaneous store and read to one address.
    step(1'b1, 1'b0, 1'b1, 1'b1, 6'd7, 8'h11);
    chk("rfirst_old", 32'(dataout), 32'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd7, '0);
    chk("rfirst_new", 32'(dataout), 32'h11);

    // Clear with a coincident store: store dropped, whole array zeroed.
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 8'h77);
    step(1'b1, 1'b1, 1'b1, 1'b0, 6'd5, 8'hFF);
    chk("clr_drop", 32'(wr_drop), 32'd1);
    count_busy("clr_busy_len");
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd5, '0);
    chk("clr_rd5", 32'(dataout), 32'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd7, '0);
    chk("clr_rd7", 32'(dataout), 32'h00);

    // Restart a sweep in flight at counter 30.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 200 && m_pos != 30; i++) idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd1, '0);
    chk("busy_rd_zero", 32'(dataout), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    count_busy("restart_busy_len");

    // Reset in the middle of a sweep at counter 20.
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 8'h99);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 200 && m_pos != 20; i++) idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("midrst_busy", 32'(busy), 32'd1);
    count_busy("midrst_busy_len");
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd2, '0);
    chk("midrst_rd2", 32'(dataout), 32'h00);

`ifdef RAM_PARITY_EN
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd9, 8'h03);
    dut.mem[9][0] = ~dut.mem[9][0];
    m_mem[9][0]   = ~m_mem[9][0];
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd9, '0);
    chk("par_err", 32'(parity_err), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 6'd9, 8'h03);
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd9, '0);
    chk("par_ok", 32'(parity_err), 32'd0);
`endif

    // Randomized traffic with rare clears and resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 149) == 0),
           1'($urandom), 1'($urandom), ADDR_W'($urandom), WIDTH'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
